jk_bank_driver: RTL and testbench

- Driver and initiator for a bank of WIDTH JK flip-flops.
- Accepts a target word over a valid/ready handshake and reads the bank's current Q vector.
- Drives per-bit J/K excitation, then issues one clock-enable strobe to the bank.
- Reads back Q: retries on mismatch up to MAX_RETRY times, then reports done or error. It is the control-side counterpart to the JK flip-flop primitives used in generated circuits.

---
 rtl/jk_bank_if.sv | 30 +++
 rtl/jk_bank_driver.sv | 154 +++++++++++++++
 tb/tb_jk_bank_driver.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_if.sv
// Handshake and bank-side bundle between the JK bank driver and its
// surroundings: target intake, Q readback, J/K excitation and status.
interface jk_bank_if #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 3
);
  localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             ff_clk_en;
  logic             busy;
  logic             done;
  logic             error;
  logic [RC_W-1:0]  retry_count;

  modport master (
    input  tgt_valid, tgt_data, q_in,
    output tgt_ready, j_out, k_out, ff_clk_en, busy, done, error, retry_count
  );

  modport slave (
    output tgt_valid, tgt_data, q_in,
    input  tgt_ready, j_out, k_out, ff_clk_en, busy, done, error, retry_count
  );
endinterface

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flip-flops toward a requested Q word: computes J/K
// excitation, strobes the bank once, reads back Q and retries on mismatch.
module jk_bank_driver #(
  parameter int WIDTH         = 4,
  parameter int MAX_RETRY     = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clock,
  input  logic       clear,
  jk_bank_if.master  bus
);
  localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int SC_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_STROBE = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  // Set only the bits that must rise; reset only the bits that must fall.
  // J and K are therefore never both high for the same bit.
  function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] t);
    return ~q & t;
  endfunction

  function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] t);
    return q & ~t;
  endfunction

  state_t           state_r;
  state_t           next_s;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] tgt_nxt_s;
  logic [WIDTH-1:0] j_r;
  logic [WIDTH-1:0] k_r;
  logic [WIDTH-1:0] j_nxt_s;
  logic [WIDTH-1:0] k_nxt_s;
  logic [RC_W-1:0]  retry_r;
  logic [RC_W-1:0]  retry_nxt_s;
  logic [SC_W-1:0]  settle_r;
  logic [SC_W-1:0]  settle_nxt_s;
  logic             settle_last_s;
  logic             match_s;
  logic             ready_r;
  logic             en_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;

  assign settle_last_s = (settle_r == SC_W'(SETTLE_CYCLES - 1));
  assign match_s       = (bus.q_in == tgt_r);

  // Next-state, excitation and counter updates for the transaction FSM.
  always_comb begin
    next_s       = state_r;
    tgt_nxt_s    = tgt_r;
    j_nxt_s      = '0;
    k_nxt_s      = '0;
    retry_nxt_s  = retry_r;
    settle_nxt_s = settle_r;
    case (state_r)
      S_IDLE: begin
        if (bus.tgt_valid && ready_r) begin
          next_s      = S_DRIVE;
          tgt_nxt_s   = bus.tgt_data;
          retry_nxt_s = '0;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_DRIVE: begin
        j_nxt_s = excite_j(bus.q_in, tgt_r);
        k_nxt_s = excite_k(bus.q_in, tgt_r);
        next_s  = S_STROBE;
      end
      S_STROBE: begin
        j_nxt_s      = j_r;
        k_nxt_s      = k_r;
        settle_nxt_s = '0;
        next_s       = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_last_s) begin
          next_s = S_CHECK;
        end else begin
          j_nxt_s      = j_r;
          k_nxt_s      = k_r;
          settle_nxt_s = settle_r + SC_W'(1);
          next_s       = S_SETTLE;
        end
      end
      S_CHECK: begin
        if (match_s) begin
          next_s = S_DONE;
        end else if (retry_r < RC_W'(MAX_RETRY)) begin
          retry_nxt_s = retry_r + RC_W'(1);
          next_s      = S_DRIVE;
        end else begin
          next_s = S_FAIL;
        end
      end
      S_DONE:  next_s = S_IDLE;
      S_FAIL:  next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
  end

  // State, datapath and outputs; outputs are decoded from the next state so
  // each one is a flop that lines up with the state it belongs to.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r  <= S_IDLE;
      tgt_r    <= '0;
      j_r      <= '0;
      k_r      <= '0;
      retry_r  <= '0;
      settle_r <= '0;
      ready_r  <= 1'b0;
      en_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= next_s;
      tgt_r    <= tgt_nxt_s;
      j_r      <= j_nxt_s;
      k_r      <= k_nxt_s;
      retry_r  <= retry_nxt_s;
      settle_r <= settle_nxt_s;
      ready_r  <= (next_s == S_IDLE);
      en_r     <= (next_s == S_STROBE);
      busy_r   <= (next_s != S_IDLE);
      done_r   <= (next_s == S_DONE);
      error_r  <= (next_s == S_FAIL);
    end
  end

  assign bus.tgt_ready   = ready_r;
  assign bus.j_out       = j_r;
  assign bus.k_out       = k_r;
  assign bus.ff_clk_en   = en_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.error       = error_r;
  assign bus.retry_count = retry_r;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed, table-driven bench for jk_bank_driver against a behavioural
// JK bank model (ideal, first-strobe-ignored, or bit0 stuck at 0).
module tb_jk_bank_driver;
  localparam int WIDTH = 4;
  localparam int MAXR  = 3;

  logic clock = 1'b0;
  logic clear;
  int   tests = 0;
  int   fails = 0;

  jk_bank_if #(.WIDTH(WIDTH), .MAX_RETRY(MAXR)) bus ();

  jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAXR), .SETTLE_CYCLES(1)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Bank model: mode 0 ideal, 1 ignores the first strobe, 2 has bit0 stuck at 0.
  logic [1:0]       mode_m;
  logic             load_m;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q_m;
  int               nstb_m;
  logic [WIDTH-1:0] stuck_m;

  assign stuck_m  = (mode_m == 2'd2) ? 4'b0001 : 4'b0000;
  assign bus.q_in = q_m;

  always @(posedge clock) begin
    if (load_m) begin
      q_m    <= load_val;
      nstb_m <= 0;
    end else if (bus.ff_clk_en) begin
      nstb_m <= nstb_m + 1;
      if (!(mode_m == 2'd1 && nstb_m == 0))
        q_m <= ((bus.j_out & ~q_m) | (~bus.k_out & q_m)) & ~stuck_m;
    end
  end

  typedef struct {
    logic [1:0]       mode;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] ej;
    logic [WIDTH-1:0] ek;
    int               estb;
    int               ecyc;
    int               eretry;
    logic             eerr;
    logic [WIDTH-1:0] eq;
    logic             poke;
  } vec_t;

  vec_t vecs[5];
  vec_t b2b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input bit do_load, input string tag);
    int cyc;
    int nstb;
    bit fin;
    logic [WIDTH-1:0] fj, fk, lj, lk;
    fj = '0; fk = '0; lj = '0; lk = '0;
    if (do_load) begin
      mode_m   = v.mode;
      load_val = v.q0;
      load_m   = 1'b1;
      @(posedge clock); #1;
      load_m   = 1'b0;
    end
    chk({tag, "_ready_idle"}, bus.tgt_ready, 1);
    bus.tgt_data  = v.tgt;
    bus.tgt_valid = 1'b1;
    @(posedge clock); #1;
    bus.tgt_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, bus.busy, 1);
    cyc  = 1;
    nstb = 0;
    fin  = 1'b0;
    while (!fin && cyc <= 40) begin
      chk({tag, "_jk_exclusive"}, bus.j_out & bus.k_out, 0);
      if (bus.ff_clk_en) begin
        if (nstb == 0) begin
          fj = bus.j_out;
          fk = bus.k_out;
        end
        lj = bus.j_out;
        lk = bus.k_out;
        nstb++;
      end
      if (bus.done || bus.error) begin
        fin = 1'b1;
        chk({tag, "_end_cycle"}, cyc, v.ecyc);
        chk({tag, "_done"}, bus.done, !v.eerr);
        chk({tag, "_error"}, bus.error, v.eerr);
      end else begin
        if (v.poke && cyc == 3) begin
          bus.tgt_data  = ~v.tgt;
          bus.tgt_valid = 1'b1;
        end else begin
          bus.tgt_valid = 1'b0;
        end
        @(posedge clock); #1;
        cyc++;
      end
    end
    bus.tgt_valid = 1'b0;
    chk({tag, "_finished"}, fin, 1);
    chk({tag, "_strobes"}, nstb, v.estb);
    chk({tag, "_retry"}, bus.retry_count, v.eretry);
    chk({tag, "_first_j"}, fj, v.ej);
    chk({tag, "_first_k"}, fk, v.ek);
    chk({tag, "_last_j"}, lj, v.ej);
    chk({tag, "_last_k"}, lk, v.ek);
    @(posedge clock); #1;
    chk({tag, "_pulse_over"}, {bus.done, bus.error, bus.busy}, 0);
    chk({tag, "_ready_back"}, bus.tgt_ready, 1);
    chk({tag, "_retry_hold"}, bus.retry_count, v.eretry);
    chk({tag, "_bank_q"}, q_m, v.eq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // mode q0 tgt j k strobes end_cycle retry err q_final poke
    vecs[0] = '{2'd0, 4'b0000, 4'b1010, 4'b1010, 4'b0000, 1, 5,  0, 1'b0, 4'b1010, 1'b0};
    vecs[1] = '{2'd0, 4'b1100, 4'b0110, 4'b0010, 4'b1000, 1, 5,  0, 1'b0, 4'b0110, 1'b0};
    vecs[2] = '{2'd1, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 2, 9,  1, 1'b0, 4'b1111, 1'b0};
    vecs[3] = '{2'd2, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4, 17, 3, 1'b1, 4'b0000, 1'b1};
    vecs[4] = '{2'd0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1, 5,  0, 1'b0, 4'b0101, 1'b0};
    b2b     = '{2'd0, 4'b0101, 4'b1010, 4'b1010, 4'b0101, 1, 5,  0, 1'b0, 4'b1010, 1'b0};

    clear         = 1'b0;
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    mode_m        = 2'd0;
    load_m        = 1'b0;
    load_val      = '0;

    // Reset state while clear is held low.
    #12;
    chk("rst_outputs", {bus.j_out, bus.k_out, bus.ff_clk_en, bus.busy, bus.done,
                        bus.error, bus.retry_count, bus.tgt_ready}, 0);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    chk("rst_release_ready", bus.tgt_ready, 1);

    // Reset asserted in SETTLE aborts the transaction with no further strobe.
    mode_m   = 2'd0;
    load_val = 4'b0000;
    load_m   = 1'b1;
    @(posedge clock); #1;
    load_m        = 1'b0;
    bus.tgt_data  = 4'b1111;
    bus.tgt_valid = 1'b1;
    @(posedge clock); #1;
    bus.tgt_valid = 1'b0;
    @(posedge clock); #1;
    chk("mid_strobe_en", bus.ff_clk_en, 1);
    @(posedge clock); #1;
    chk("mid_settle_j", bus.j_out, 4'b1111);
    clear = 1'b0;
    #1;
    chk("mid_rst_jk", {bus.j_out, bus.k_out}, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.tgt_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_strobe", bus.ff_clk_en, 0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    chk("mid_rst_release_ready", bus.tgt_ready, 1);
    chk("mid_rst_release_busy", bus.busy, 0);

    for (int i = 0; i < 5; i++) begin
      run(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Back-to-back: next target presented in the IDLE cycle right after DONE.
    run(b2b, 1'b0, "b2b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
